// File: rtl/hmj_ld_pkg.sv
// Shared definitions for the HMJ mmWave radar UART link.
// Holds the command-frame constants, the serialiser state encoding and the
// frame checksum helper used by the command transmitter.
package hmj_ld_pkg;

  localparam logic [7:0]  LD_HDR0          = 8'h55;
  localparam logic [7:0]  LD_HDR1          = 8'hAA;
  localparam logic [7:0]  LD_TAIL          = 8'h0D;
  localparam int unsigned LD_CMD_FRAME_LEN = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } ld_state_e;

  // 8-bit wrapping sum of the command byte and both parameter bytes.
  function automatic logic [7:0] ld_chk8(input logic [7:0] cmd, input logic [15:0] param);
    return cmd + param[15:8] + param[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first.
// Ports:
//   sys_clk   - system clock
//   sys_rst   - asynchronous reset, active-high
//   valid     - byte offered; taken when ready is high
//   data      - byte to send
//   ready     - idle, or in the final cycle of the stop bit
//   txd       - serial line, idles high
//   byte_done - high in the final cycle of the stop bit
module uart_tx_byte
  import hmj_ld_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd,
  output logic       byte_done
);

  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

  ld_state_e   st;
  logic [9:0]  shreg;
  logic [3:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic        tick;

  always_comb begin
    tick      = (baud_cnt == DIV_LAST);
    byte_done = (st == STOP) && tick;
    // Accepting during the stop bit's last cycle lets the next start bit
    // follow with no idle time on the line.
    ready     = (st == IDLE) || byte_done;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      st       <= IDLE;
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b1;
    end else if (valid && ready) begin
      st       <= START;
      shreg    <= {1'b1, data, 1'b0};
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b0;
    end else if (st != IDLE) begin
      if (!tick) begin
        baud_cnt <= baud_cnt + 16'd1;
      end else begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
        shreg    <= {1'b1, shreg[9:1]};
        txd      <= shreg[1];
        case (st)
          START:   st <= DATA;
          DATA:    if (bit_cnt == 4'd8) st <= STOP;
          STOP: begin
            st      <= IDLE;
            bit_cnt <= '0;
            txd     <= 1'b1;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/hmj_ld_cmd_tx.sv
// Radar command-frame transmitter.
// On an accepted start pulse, latches the command and parameter and sends
// 55 AA CMD PARAM_HI PARAM_LO CHK 0D as 8N1 bytes, with GAP_BITS idle
// bit-times between bytes.
// Ports:
//   i_sys_clk  - system clock
//   i_sys_rst  - asynchronous reset, active-high
//   i_start    - frame request, accepted only while o_busy=0
//   i_cmd      - command byte, sampled on accept
//   i_param    - 16-bit parameter, sampled on accept
//   o_uart_txd - serial output, idle high
//   o_busy     - frame in progress
//   o_done     - one-cycle pulse after the last stop bit
//   o_overrun  - one-cycle pulse for a request dropped while busy
module hmj_ld_cmd_tx
  import hmj_ld_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned GAP_BITS = 0
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_start,
  input  logic [7:0]  i_cmd,
  input  logic [15:0] i_param,
  output logic        o_uart_txd,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overrun
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned GAP_CYC  = GAP_BITS * BAUD_DIV;
  localparam logic [19:0] GAP_LAST = 20'(GAP_CYC - 1);
  localparam logic [2:0]  LAST_IDX = 3'(LD_CMD_FRAME_LEN - 1);
  localparam bit          NO_GAP   = (GAP_BITS == 0);

  logic [7:0]  cmd_q;
  logic [15:0] param_q;
  logic [7:0]  chk_q;
  logic [2:0]  byte_idx;
  logic        gap_on;
  logic [19:0] gap_cnt;

  logic        accept;
  logic        more;
  logic        gap_end;
  logic        tx_valid;
  logic        tx_ready;
  logic        byte_done;
  logic [2:0]  sel_idx;
  logic [7:0]  tx_data;

  always_comb begin
    accept   = i_start && !o_busy && tx_ready;
    more     = (byte_idx != LAST_IDX);
    gap_end  = gap_on && (gap_cnt == GAP_LAST);
    tx_valid = accept || gap_end || (byte_done && more && NO_GAP);
    // byte_idx already points at the next byte once a gap has started;
    // without a gap the next byte is handed over in the stop bit's last cycle.
    if (accept)      sel_idx = 3'd0;
    else if (gap_on) sel_idx = byte_idx;
    else             sel_idx = byte_idx + 3'd1;
    case (sel_idx)
      3'd0:    tx_data = LD_HDR0;
      3'd1:    tx_data = LD_HDR1;
      3'd2:    tx_data = cmd_q;
      3'd3:    tx_data = param_q[15:8];
      3'd4:    tx_data = param_q[7:0];
      3'd5:    tx_data = chk_q;
      default: tx_data = LD_TAIL;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      cmd_q     <= '0;
      param_q   <= '0;
      chk_q     <= '0;
      byte_idx  <= '0;
      gap_on    <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      o_done    <= 1'b0;
      o_overrun <= i_start && o_busy;
      if (accept) begin
        o_busy   <= 1'b1;
        cmd_q    <= i_cmd;
        param_q  <= i_param;
        chk_q    <= ld_chk8(i_cmd, i_param);
        byte_idx <= '0;
      end
      if (byte_done) begin
        if (more) begin
          byte_idx <= byte_idx + 3'd1;
          if (!NO_GAP) begin
            gap_on  <= 1'b1;
            gap_cnt <= '0;
          end
        end else begin
          o_busy   <= 1'b0;
          o_done   <= 1'b1;
          byte_idx <= '0;
        end
      end
      if (gap_on) begin
        if (gap_end) begin
          gap_on  <= 1'b0;
          gap_cnt <= '0;
        end else begin
          gap_cnt <= gap_cnt + 20'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .sys_clk  (i_sys_clk),
    .sys_rst  (i_sys_rst),
    .valid    (tx_valid),
    .data     (tx_data),
    .ready    (tx_ready),
    .txd      (o_uart_txd),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_hmj_ld_cmd_tx.sv
// Bench for hmj_ld_cmd_tx: three instances (default rate, default rate with a
// 2-bit gap, fast rate) checked cycle by cycle against a line model built
// from the frame bytes and bit-time arithmetic.
module tb_hmj_ld_cmd_tx;

  logic        clk;
  logic        rst;
  logic [2:0]  start;
  logic [2:0]  txd;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [2:0]  ovr;
  logic [7:0]  cmd   [3];
  logic [15:0] param [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hmj_ld_cmd_tx #(.CLK_FREQ(50_000_000), .BAUD(115200), .GAP_BITS(0)) u_dut_a (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start[0]), .i_cmd(cmd[0]), .i_param(param[0]),
    .o_uart_txd(txd[0]), .o_busy(busy[0]), .o_done(done[0]), .o_overrun(ovr[0]));

  hmj_ld_cmd_tx #(.CLK_FREQ(50_000_000), .BAUD(115200), .GAP_BITS(2)) u_dut_b (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start[1]), .i_cmd(cmd[1]), .i_param(param[1]),
    .o_uart_txd(txd[1]), .o_busy(busy[1]), .o_done(done[1]), .o_overrun(ovr[1]));

  hmj_ld_cmd_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .GAP_BITS(0)) u_dut_c (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start[2]), .i_cmd(cmd[2]), .i_param(param[2]),
    .o_uart_txd(txd[2]), .o_busy(busy[2]), .o_done(done[2]), .o_overrun(ovr[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sends one frame on instance sel starting at the current negedge and
  // follows it to the o_done cycle. coll_j >= 0 raises i_start again at that
  // cycle offset. Returns at the negedge where o_done is expected.
  task automatic run_frame(input int sel, input logic [7:0] c, input logic [15:0] p,
                           input int div, input int gap, input int coll_j, input string tag);
    logic [7:0] exp_b [7];
    logic [7:0] got_b [7];
    int data_len, slot_len, total, sum;
    int e_txd, e_busy, e_ovr, n_done, done_at;
    int slot, w, bitn;
    logic exp_txd, exp_busy, exp_ovr;

    sum      = c + p[15:8] + p[7:0];
    exp_b[0] = 8'h55;
    exp_b[1] = 8'hAA;
    exp_b[2] = c;
    exp_b[3] = p[15:8];
    exp_b[4] = p[7:0];
    exp_b[5] = 8'(sum % 256);
    exp_b[6] = 8'h0D;
    for (int i = 0; i < 7; i++) got_b[i] = '0;
    data_len = 10 * div;
    slot_len = data_len + gap * div;
    total    = 7 * data_len + 6 * gap * div;
    e_txd = 0; e_busy = 0; e_ovr = 0; n_done = 0; done_at = -1;

    cmd[sel]   = c;
    param[sel] = p;
    start[sel] = 1'b1;
    for (int j = 0; j <= total; j++) begin
      @(negedge clk);
      if (j == 0) start[sel] = 1'b0;
      exp_txd = 1'b1;
      if (j < total) begin
        slot = j / slot_len;
        w    = j % slot_len;
        if (w < data_len) begin
          bitn = w / div;
          if (bitn == 0) exp_txd = 1'b0;
          else if (bitn <= 8) begin
            exp_txd = exp_b[slot][bitn-1];
            if (w % div == div / 2) got_b[slot][bitn-1] = txd[sel];
          end
        end
      end
      exp_busy = (j < total);
      exp_ovr  = (coll_j >= 0) && (j == coll_j + 1);
      if (txd[sel] !== exp_txd) e_txd++;
      if (busy[sel] !== exp_busy) e_busy++;
      if (ovr[sel] !== exp_ovr) e_ovr++;
      if (done[sel] === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = j;
      end
      if (j == coll_j) start[sel] = 1'b1;
      if (coll_j >= 0 && j == coll_j + 1) start[sel] = 1'b0;
      if (j > 0 && j < total) begin
        cmd[sel]   = 8'($urandom);
        param[sel] = 16'($urandom);
      end
    end
    check_eq({tag, "_txd_errs"}, e_txd, 0);
    check_eq({tag, "_busy_errs"}, e_busy, 0);
    check_eq({tag, "_ovr_errs"}, e_ovr, 0);
    check_eq({tag, "_done_cnt"}, n_done, 1);
    check_eq({tag, "_done_at"}, done_at, total);
    for (int i = 0; i < 7; i++) check_eq({tag, "_byte", $sformatf("%0d", i)}, got_b[i], exp_b[i]);
  endtask

  // Starts a frame on the fast instance and hits reset during byte 3's data bits.
  task automatic reset_mid(input int div);
    cmd[2]     = 8'($urandom);
    param[2]   = 16'($urandom);
    start[2]   = 1'b1;
    @(negedge clk);
    start[2]   = 1'b0;
    repeat (34 * div) @(negedge clk);
    check_eq("rst_mid_busy_before", busy[2], 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_txd_async", txd[2], 1);
    check_eq("rst_mid_busy_async", busy[2], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mid_txd_idle", txd[2], 1);
    check_eq("rst_mid_done", done[2], 0);
  endtask

  initial begin
    int coll;
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < 3; i++) begin
      cmd[i]   = '0;
      param[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("reset_txd%0d", i), txd[i], 1);
      check_eq($sformatf("reset_busy%0d", i), busy[i], 0);
      check_eq($sformatf("reset_done%0d", i), done[i], 0);
      check_eq($sformatf("reset_ovr%0d", i), ovr[i], 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Default rate: basic frame with a dropped request 1000 cycles in.
    run_frame(0, 8'h01, 16'h0032, 434, 0, 1000, "basic");
    // Default rate, two idle bit-times between bytes.
    run_frame(1, 8'($urandom), 16'($urandom), 434, 2, -1, "gap2");
    // Fast instance: checksum wrap, then back-to-back frames.
    repeat (2) @(negedge clk);
    run_frame(2, 8'hFF, 16'h0102, 10, 0, -1, "wrap");
    for (int i = 0; i < 3; i++)
      run_frame(2, 8'($urandom), 16'($urandom), 10, 0, -1, $sformatf("b2b%0d", i));
    repeat (5) @(negedge clk);
    check_eq("idle_txd", txd[2], 1);
    check_eq("idle_busy", busy[2], 0);

    reset_mid(10);
    run_frame(2, 8'($urandom), 16'($urandom), 10, 0, -1, "post_rst");

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      coll = (i % 2 == 1) ? int'($urandom_range(0, 650)) : -1;
      run_frame(2, 8'($urandom), 16'($urandom), 10, 0, coll, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
